// File: rtl/sync_debounce_ctrl.sv
// Synchronizes an asynchronous input, debounces it on enabled sample ticks,
// and publishes a clean level plus one-cycle rise/fall pulses.
module sync_debounce_ctrl #(
  parameter int unsigned N_STAGES   = 2,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    CHK1    = 2'd1,
    STABLE1 = 2'd2,
    CHK0    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [N_STAGES-1:0] sync_q;
  logic                s;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                q_q, q_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  assign s = sync_q[N_STAGES-1];

  // State register, including the free-running synchronizer chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= STABLE0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[N_STAGES-2:0], d};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: only enabled samples advance qualification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      case (state_q)
        STABLE0: begin
          if (s) begin
            state_d = CHK1;
            cnt_d   = CntOne;
          end
        end
        CHK1: begin
          if (!s) begin
            state_d = STABLE0;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = STABLE1;
            cnt_d   = '0;
            q_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        STABLE1: begin
          if (!s) begin
            state_d = CHK0;
            cnt_d   = CntOne;
          end
        end
        CHK0: begin
          if (s) begin
            state_d = STABLE1;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = STABLE0;
            cnt_d   = '0;
            q_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = STABLE0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from registered state.
  always_comb begin
    q    = q_q;
    rise = rise_q;
    fall = fall_q;
    busy = (state_q == CHK1) || (state_q == CHK0);
  end

endmodule

// File: tb/tb_sync_debounce_ctrl.sv
// Bench for sync_debounce_ctrl: directed scenarios plus random stimulus,
// checked every cycle against a sample-counting behavioural model.
module tb_sync_debounce_ctrl;

  localparam int unsigned N_STAGES   = 2;
  localparam int unsigned DEB_CYCLES = 4;
  localparam int unsigned CNT_W      = 8;

  logic clk = 1'b0;
  logic reset, d, en;
  logic q, rise, fall, busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: delayed copy of d, current clean level, run of opposite samples.
  logic m_hist [N_STAGES];
  logic m_q, m_rise, m_fall;
  int   m_run;

  sync_debounce_ctrl #(
    .N_STAGES  (N_STAGES),
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .en   (en),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(N_STAGES); i++) m_hist[i] = 1'b0;
    m_q    = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run  = 0;
  endtask

  task automatic model_edge(input logic dv, input logic ev);
    logic s;
    s      = m_hist[N_STAGES-1];
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (ev) begin
      if (s == m_q) m_run = 0;
      else begin
        m_run++;
        if (m_run == int'(DEB_CYCLES)) begin
          m_q    = s;
          m_rise = s;
          m_fall = ~s;
          m_run  = 0;
        end
      end
    end
    for (int i = int'(N_STAGES) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = dv;
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_q"},    32'(q),    32'(m_q));
    chk({ph, "_rise"}, 32'(rise), 32'(m_rise));
    chk({ph, "_fall"}, 32'(fall), 32'(m_fall));
    chk({ph, "_busy"}, 32'(busy), 32'(m_run != 0));
    chk({ph, "_cnt"},  32'(dut.cnt_q), 32'(m_run));
  endtask

  task automatic step(input logic dv, input logic ev, input string ph);
    d  = dv;
    en = ev;
    @(posedge clk);
    model_edge(dv, ev);
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    int edge_at;
    int busy_cnt;
    int rise_cnt;
    int guard;
    logic lvl;
    int len;

    reset = 1'b1;
    d     = 1'b0;
    en    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // Idle low with en held high
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, "t1_idle");

    // Clean rise: busy after edge 3, q/rise at edge 6
    edge_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, "t2_rise");
      if (i == 2) chk("t2_busy_edge2", 32'(busy), 32'd0);
      if (i == 3) chk("t2_busy_edge3", 32'(busy), 32'd1);
      if (rise === 1'b1 && edge_at < 0) edge_at = i;
    end
    chk("t2_rise_edge", 32'(edge_at), 32'd6);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, "t2_hold");

    // Clean fall from q=1
    edge_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, "t5_fall");
      if (fall === 1'b1 && edge_at < 0) edge_at = i;
    end
    chk("t5_fall_edge", 32'(edge_at), 32'(N_STAGES + DEB_CYCLES));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "t5_hold");

    // Two-cycle glitch must be rejected
    busy_cnt = 0;
    rise_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step((i < 2) ? 1'b1 : 1'b0, 1'b1, "t3_glitch");
      if (busy === 1'b1) busy_cnt++;
      if (rise === 1'b1) rise_cnt++;
    end
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd2);
    chk("t3_rise_count", 32'(rise_cnt), 32'd0);
    chk("t3_q_low", 32'(q), 32'd0);

    // Sparse enable: only every third cycle samples
    for (int i = 0; i < 30; i++) step(1'b1, (i % 3) == 0, "t4_sparse");
    chk("t4_q_high", 32'(q), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "t4_restore");

    // Async reset mid-qualification
    guard = 0;
    while (m_run != 2 && guard < 10) begin
      step(1'b1, 1'b1, "t6_pre");
      guard++;
    end
    chk("t6_reached_cnt2", 32'(m_run), 32'd2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    @(posedge clk);
    @(negedge clk);
    check_all("t6_in_reset");
    reset = 1'b0;
    edge_at  = -1;
    rise_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, "t6_after");
      if (rise === 1'b1) begin
        rise_cnt++;
        if (edge_at < 0) edge_at = i;
      end
    end
    chk("t6_rise_edge", 32'(edge_at), 32'd6);
    chk("t6_rise_count", 32'(rise_cnt), 32'd1);

    // Random segments of held levels with random enable ticks
    for (int seg = 0; seg < 80; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) step(lvl, $urandom_range(0, 3) != 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
